// File: rtl/dds_pkg.sv
// Shared constants and types for the dds_core phase accumulator / sine NCO.
package dds_pkg;

  localparam int ACC_W_DEF   = 32;
  localparam int PHASE_W_DEF = 12;
  localparam int OUT_W_DEF   = 12;

  function automatic int midscale(int w);
    return 1 << (w - 1);
  endfunction

  localparam int MIDSCALE = midscale(OUT_W_DEF);

  // Fibonacci LFSR, taps 16,14,13,11 as a mask over bits [15:0]
  localparam logic [15:0] LFSR_SEED = 16'hACE1;
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  typedef logic [1:0] quadrant_t;

endpackage

// File: rtl/dds_sine_rom.sv
// Registered quarter-wave sine ROM, 1-cycle read latency.
// Contents are generated at elaboration: round((2^(OUT_W-1)-1)*sin(2*pi*(i+0.5)/2^PHASE_W)).
module dds_sine_rom #(
  parameter int PHASE_W = 12,
  parameter int OUT_W   = 12
) (
  input  logic               clk,
  input  logic               en,
  input  logic [PHASE_W-3:0] addr,
  output logic [OUT_W-2:0]   mag
);

  localparam int DEPTH   = 1 << (PHASE_W - 2);
  localparam int MAG_W   = OUT_W - 1;
  localparam int MAX_MAG = (1 << (OUT_W - 1)) - 1;
  localparam longint PI_Q50 = 64'sd3537118876014220;

  // Fixed-point Q30 Taylor series; x < pi/2 so ten terms are far below an LSB.
  function automatic logic [MAG_W-1:0] sine_entry(int idx);
    longint x, x2, term, sum;
    x    = (PI_Q50 * longint'(2 * idx + 1)) >>> (20 + PHASE_W);
    x2   = (x * x) >>> 30;
    term = x;
    sum  = x;
    for (int n = 1; n <= 10; n++) begin
      term = -((term * x2) >>> 30) / longint'((2 * n) * (2 * n + 1));
      sum  = sum + term;
    end
    return MAG_W'((longint'(MAX_MAG) * sum + (longint'(1) <<< 29)) >>> 30);
  endfunction

  logic [MAG_W-1:0] rom [DEPTH];

  for (genvar i = 0; i < DEPTH; i++) begin : g_rom
    localparam logic [MAG_W-1:0] ENTRY = sine_entry(i);
    assign rom[i] = ENTRY;
  end

  always_ff @(posedge clk)
    if (en) mag <= rom[addr];

endmodule

// File: rtl/dds_core.sv
// Phase accumulator NCO with 3-stage quarter-wave sine lookup, offset-binary output.
// Define DDS_PHASE_DITHER_EN to add LFSR dither below the lookup truncation point.
module dds_core import dds_pkg::*; #(
  parameter int ACC_W   = ACC_W_DEF,
  parameter int PHASE_W = PHASE_W_DEF,
  parameter int OUT_W   = OUT_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [ACC_W-1:0] ftw_in,
  input  logic             ftw_valid,
  input  logic             enable,
  input  logic             phase_sync,
  output logic [OUT_W-1:0] sample_out,
  output logic             sample_valid,
  output logic [ACC_W-1:0] phase_out,
  output logic [ACC_W-1:0] ftw_active
);

  localparam int ADDR_W = PHASE_W - 2;
  localparam int MAG_W  = OUT_W - 1;
  localparam int STAGES = 3;
  localparam logic [OUT_W-1:0] MID = OUT_W'(midscale(OUT_W));

  logic [ACC_W-1:0]  acc;
  logic [STAGES:0]   vld_pipe;

  // vld_pipe[0] marks acc as a fresh sample; later bits gate each stage
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      acc        <= '0;
      ftw_active <= '0;
      vld_pipe   <= '0;
    end else begin
      if (ftw_valid) ftw_active <= ftw_in;
      if (phase_sync)  acc <= '0;
      else if (enable) acc <= acc + ftw_active;
      vld_pipe <= {vld_pipe[STAGES-1:0], enable};
    end

  assign phase_out    = acc;
  assign sample_valid = vld_pipe[STAGES];

  logic [PHASE_W-1:0] p;

`ifdef DDS_PHASE_DITHER_EN
  logic [15:0]              lfsr;
  logic [ACC_W-PHASE_W-1:0] dith;

  always_ff @(posedge clk or posedge rst)
    if (rst) lfsr <= LFSR_SEED;
    else     lfsr <= {lfsr[14:0], ^(lfsr & LFSR_TAPS)};

  assign dith = (ACC_W - PHASE_W)'(lfsr);
  assign p    = PHASE_W'((acc + ACC_W'(dith)) >> (ACC_W - PHASE_W));
`else
  assign p = acc[ACC_W-1 -: PHASE_W];
`endif

  quadrant_t         q;
  logic [ADDR_W-1:0] addr_c, addr1;
  logic              sign1, sign2;
  logic [MAG_W-1:0]  mag;

  // Odd quadrants read the quarter table backwards
  assign q      = p[PHASE_W-1 -: 2];
  assign addr_c = q[0] ? ~p[ADDR_W-1:0] : p[ADDR_W-1:0];

  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      addr1      <= '0;
      sign1      <= 1'b0;
      sign2      <= 1'b0;
      sample_out <= MID;
    end else begin
      if (vld_pipe[0]) begin
        addr1 <= addr_c;
        sign1 <= q[1];
      end
      if (vld_pipe[1]) sign2 <= sign1;
      if (vld_pipe[2]) sample_out <= sign2 ? MID - OUT_W'(mag) : MID + OUT_W'(mag);
    end

  dds_sine_rom #(.PHASE_W(PHASE_W), .OUT_W(OUT_W)) u_rom (
    .clk  (clk),
    .en   (vld_pipe[1]),
    .addr (addr1),
    .mag  (mag)
  );

endmodule
